exec_trace_buffer: RTL and testbench
====================================

# exec_trace_buffer

Parametrised hardware execution-trace capture unit for the single-cycle RISC-V core. Each retired instruction's PC and decoded control word (pcsel, immsel, regwen, brun, asel, bsel, alusel, memrw, wbsel, packed by the datapath) is recorded into a circular buffer of depth DEPTH. Capture stops a programmable number of samples after a PC-match or forced trigger. The retained window is then streamed out oldest-first over a valid/ready port. The block sits beside the datapath and observes its outputs only; it never stalls the core.

## Interface
- DEPTH, 16: buffer entries; power of two, ≥ 4.
- PC_W, 32: PC width.
- CTRL_W, 14: packed control-word width.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cap_valid  in  1  instruction retires this cycle; sample cap_pc/cap_ctrl.
- cap_pc  in  PC_W  retiring PC.
- cap_ctrl  in  CTRL_W  retiring control word.
- arm  in  1  pulse: clear buffer and start capture.
- post_len  in  $clog2(DEPTH)  samples to keep after the trigger sample; latched on arm.
- trig_en  in  1  enable PC-match trigger.
- trig_pc  in  PC_W  trigger PC; compared live.
- force_trig  in  1  pulse: trigger unconditionally.
- rd_valid  out  1  rd_pc/rd_ctrl hold a buffered entry.
- rd_ready  in  1  consumer accepts the entry.
- rd_pc  out  PC_W  entry PC.
- rd_ctrl  out  CTRL_W  entry control word.
- rd_last  out  1  current entry is the final one.
- armed  out  1  in ARMED or POST.
- done  out  1  in DONE.
- count  out  $clog2(DEPTH)+1  entries retained; saturates at DEPTH.
- wrapped  out  1  at least one entry was overwritten.

## Operation
- States: IDLE, ARMED, POST, DONE. Reset → IDLE, and every output and counter is 0.
- Priority: rst > arm > all other events.
- In IDLE, capture inputs are ignored.
- arm (any state): go to ARMED. Clear wr_ptr, count and wrapped, and latch post_len.
- Write (ARMED/POST, cap_valid=1):
  - mem[wr_ptr] ← {cap_pc, cap_ctrl}.
  - wr_ptr increments mod DEPTH.
  - count increments, saturating at DEPTH. If count was already DEPTH, set wrapped (sticky until arm).
- Trigger (ARMED only):
  - Fires if cap_valid && trig_en && cap_pc==trig_pc, or if force_trig is high.
  - The trigger-cycle sample is written when cap_valid=1. force_trig without cap_valid writes nothing.
  - post_len==0 → DONE; otherwise POST with remaining=post_len.
- POST: each write decrements remaining. When the write brings remaining to 0, go to DONE. Cycles without cap_valid do not decrement. Triggers are ignored.
- DONE:
  - rd_ptr = wrapped ? wr_ptr : 0; left = count.
  - rd_valid = (left≠0). rd_pc/rd_ctrl = mem[rd_ptr] (combinational read). rd_last = (left==1).
  - Each rd_valid&&rd_ready handshake advances rd_ptr mod DEPTH and decrements left.
  - After the rd_last handshake, or on the cycle after entering DONE with count==0, go to IDLE.
  - cap_valid is ignored in DONE.
- Transfer rules: while rd_valid&&!rd_ready, rd_pc, rd_ctrl and rd_last hold stable. Every entry is delivered exactly once.
- count and wrapped keep their values through DONE and IDLE until the next arm.

## Timing
- Capture latency: a sample is in mem and reflected in count the cycle after its cap_valid edge.
- Trigger → DONE:
  - post_len=0: 1 cycle after the trigger edge.
  - Otherwise: 1 cycle after the post_len-th post-trigger cap_valid.
- rd_valid rises on the first cycle in DONE; no read bubbles.
- Read throughput: one entry per cycle with rd_ready held high.
- Back-to-back arm pulses each restart the capture cleanly.
- rst in mid-read drops rd_valid and clears all state on the next edge.
- No combinational path from rd_ready to rd_valid.

## Test plan
- DEPTH=8, post_len=2, trig_en=1, trig_pc=0x10; cap_valid every cycle with PCs 0x00,0x04,…:
  - Trigger fires at 0x10; DONE follows after 0x18.
  - count=7, wrapped=0.
  - Readout is 0x00…0x18 with matching ctrl; rd_last only on 0x18.
- Wrap: same setup with trig_pc=0x30, post_len=3:
  - 16 writes; count=8, wrapped=1.
  - Readout is 0x20…0x3C, oldest first.
- Backpressure: rd_ready pattern 1,0,0,1,0,1…:
  - rd_pc/rd_ctrl stable while stalled.
  - All 8 entries delivered once, in order; rd_last only on the final transfer.
- POST gaps: trigger with post_len=3, then cap_valid pattern 1,0,0,1,0,1 → DONE one cycle after the third post-trigger sample; gap cycles do not count.
- force_trig at post_len=0 right after arm, with cap_valid=0:
  - done high for 1 cycle, then IDLE.
  - rd_valid never asserts; count=0.
- Restart and reset:
  - arm in mid-POST → armed=1, count=0, wrapped=0 next cycle, and the new capture proceeds normally.
  - rst asserted during readout → all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/exec_trace_buffer.sv
// -----------------------------------------------------------------------------
// exec_trace_buffer
//
// Execution-trace capture unit for the single-cycle RISC-V core. Every retired
// instruction's PC and packed control word is written into a circular buffer.
// Capture is armed by a pulse, and a PC-match or forced trigger starts a
// post-trigger countdown. When the countdown ends the retained window is
// streamed out oldest-first over a valid/ready port. The block only observes
// the datapath and never stalls it.
//
// Parameters
//   DEPTH   buffer entries (power of two, >= 4)
//   PC_W    PC width
//   CTRL_W  packed control-word width
//
// Ports
//   clk_i         clock, all state changes on the rising edge
//   rst_i         synchronous active-high reset
//   cap_valid_i   instruction retires this cycle
//   cap_pc_i      retiring PC
//   cap_ctrl_i    retiring control word
//   arm_i         pulse: clear buffer, latch post_len_i, start capture
//   post_len_i    samples kept after the trigger sample
//   trig_en_i     enable PC-match trigger
//   trig_pc_i     trigger PC (compared live)
//   force_trig_i  pulse: unconditional trigger
//   rd_valid_o    rd_pc_o/rd_ctrl_o hold a buffered entry
//   rd_ready_i    consumer accepts the entry
//   rd_pc_o       entry PC
//   rd_ctrl_o     entry control word
//   rd_last_o     current entry is the final one
//   armed_o       capturing (waiting for trigger or counting post samples)
//   done_o        capture finished, readout in progress
//   count_o       entries retained, saturates at DEPTH
//   wrapped_o     at least one entry was overwritten
// -----------------------------------------------------------------------------
module exec_trace_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned CTRL_W = 14
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cap_valid_i,
    input  logic [PC_W-1:0]          cap_pc_i,
    input  logic [CTRL_W-1:0]        cap_ctrl_i,
    input  logic                     arm_i,
    input  logic [$clog2(DEPTH)-1:0] post_len_i,
    input  logic                     trig_en_i,
    input  logic [PC_W-1:0]          trig_pc_i,
    input  logic                     force_trig_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [PC_W-1:0]          rd_pc_o,
    output logic [CTRL_W-1:0]        rd_ctrl_o,
    output logic                     rd_last_o,
    output logic                     armed_o,
    output logic                     done_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     wrapped_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = AW + 1;
    localparam int unsigned EW   = PC_W + CTRL_W;

    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [CntW-1:0] OneCnt   = CntW'(1);
    localparam logic [AW-1:0]   OneRem   = AW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StPost,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            wrapped_q, wrapped_d;
    logic [AW-1:0]   post_len_q, post_len_d;
    logic [AW-1:0]   remaining_q, remaining_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] left_q, left_d;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   rd_entry;
    logic            wr_en;
    logic            trig_hit;

    assign trig_hit = force_trig_i |
                      (cap_valid_i & trig_en_i & (cap_pc_i == trig_pc_i));

    // Next-state logic. arm_i overrides everything except reset, and the
    // arm cycle itself records nothing.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        wrapped_d   = wrapped_q;
        post_len_d  = post_len_q;
        remaining_d = remaining_q;
        rd_ptr_d    = rd_ptr_q;
        left_d      = left_q;
        wr_en       = 1'b0;

        if (arm_i) begin
            state_d    = StArmed;
            wr_ptr_d   = '0;
            count_d    = '0;
            wrapped_d  = 1'b0;
            post_len_d = post_len_i;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Capture inputs are ignored until the next arm.
                end

                StArmed, StPost: begin
                    if (cap_valid_i) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (count_q == DepthCnt) begin
                            wrapped_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end

                    if (state_q == StArmed) begin
                        if (trig_hit) begin
                            if (post_len_q == '0) begin
                                state_d = StDone;
                            end else begin
                                state_d     = StPost;
                                remaining_d = post_len_q;
                            end
                        end
                    end else if (cap_valid_i) begin
                        // Only real samples count down the post-trigger window.
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == OneRem) begin
                            state_d = StDone;
                        end
                    end

                    // Seed the reader from the post-write pointers so the first
                    // DONE cycle already presents the oldest entry.
                    if (state_d == StDone) begin
                        rd_ptr_d = wrapped_d ? wr_ptr_d : '0;
                        left_d   = count_d;
                    end
                end

                StDone: begin
                    if (left_q == '0) begin
                        state_d = StIdle;
                    end else if (rd_ready_i) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        left_d   = left_q - 1'b1;
                        if (left_q == OneCnt) begin
                            state_d = StIdle;
                        end
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            wrapped_q   <= 1'b0;
            post_len_q  <= '0;
            remaining_q <= '0;
            rd_ptr_q    <= '0;
            left_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            wrapped_q   <= wrapped_d;
            post_len_q  <= post_len_d;
            remaining_q <= remaining_d;
            rd_ptr_q    <= rd_ptr_d;
            left_q      <= left_d;
        end
    end

    // Trace storage has no reset; validity is tracked by count_q/left_q.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) begin
            mem_q[wr_ptr_q] <= {cap_pc_i, cap_ctrl_i};
        end
    end

    // All outputs decode registered state only, so rd_ready_i has no
    // combinational path to rd_valid_o.
    assign rd_entry   = mem_q[rd_ptr_q];
    assign rd_valid_o = (state_q == StDone) && (left_q != '0);
    assign rd_pc_o    = rd_valid_o ? rd_entry[EW-1:CTRL_W] : '0;
    assign rd_ctrl_o  = rd_valid_o ? rd_entry[CTRL_W-1:0] : '0;
    assign rd_last_o  = rd_valid_o && (left_q == OneCnt);
    assign armed_o    = (state_q == StArmed) || (state_q == StPost);
    assign done_o     = (state_q == StDone);
    assign count_o    = count_q;
    assign wrapped_o  = wrapped_q;

endmodule

// File: tb/tb_exec_trace_buffer.sv
module tb_exec_trace_buffer;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned CTRL_W = 14;
    localparam int unsigned AW     = 3;
    localparam int unsigned EW     = PC_W + CTRL_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cap_valid = 1'b0;
    logic [PC_W-1:0]   cap_pc = '0;
    logic [CTRL_W-1:0] cap_ctrl = '0;
    logic              arm = 1'b0;
    logic [AW-1:0]     post_len = '0;
    logic              trig_en = 1'b0;
    logic [PC_W-1:0]   trig_pc = '0;
    logic              force_trig = 1'b0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [PC_W-1:0]   rd_pc;
    logic [CTRL_W-1:0] rd_ctrl;
    logic              rd_last;
    logic              armed;
    logic              done;
    logic [AW:0]       count;
    logic              wrapped;

    always #5 clk = ~clk;

    exec_trace_buffer #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W),
        .CTRL_W(CTRL_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cap_valid_i (cap_valid),
        .cap_pc_i    (cap_pc),
        .cap_ctrl_i  (cap_ctrl),
        .arm_i       (arm),
        .post_len_i  (post_len),
        .trig_en_i   (trig_en),
        .trig_pc_i   (trig_pc),
        .force_trig_i(force_trig),
        .rd_valid_o  (rd_valid),
        .rd_ready_i  (rd_ready),
        .rd_pc_o     (rd_pc),
        .rd_ctrl_o   (rd_ctrl),
        .rd_last_o   (rd_last),
        .armed_o     (armed),
        .done_o      (done),
        .count_o     (count),
        .wrapped_o   (wrapped)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [CTRL_W-1:0] ctrl_of(input logic [PC_W-1:0] pc);
        return pc[15:2] ^ 14'h2A5;
    endfunction

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 waiting for trigger, 2 post-trigger, 3 reading out.
    // m_buf is the retained window (oldest first, at most DEPTH long);
    // m_rdq is what remains to be delivered.
    int            m_mode = 0;
    logic [EW-1:0] m_buf[$];
    logic [EW-1:0] m_rdq[$];
    int            m_total = 0;
    int            m_post_len = 0;
    int            m_rem = 0;

    task automatic model_tick();
        if (rst) begin
            m_mode = 0;
            m_buf.delete();
            m_rdq.delete();
            m_total = 0;
        end else if (arm) begin
            m_mode = 1;
            m_buf.delete();
            m_rdq.delete();
            m_total = 0;
            m_post_len = int'(post_len);
        end else if (m_mode == 1 || m_mode == 2) begin
            bit finish = 1'b0;
            if (cap_valid) begin
                m_buf.push_back({cap_pc, cap_ctrl});
                m_total++;
                if (m_buf.size() > DEPTH) void'(m_buf.pop_front());
            end
            if (m_mode == 1) begin
                if (force_trig || (cap_valid && trig_en && cap_pc == trig_pc)) begin
                    if (m_post_len == 0) finish = 1'b1;
                    else begin
                        m_mode = 2;
                        m_rem = m_post_len;
                    end
                end
            end else if (cap_valid) begin
                m_rem--;
                if (m_rem == 0) finish = 1'b1;
            end
            if (finish) begin
                m_mode = 3;
                m_rdq = m_buf;
            end
        end else if (m_mode == 3) begin
            if (m_rdq.size() == 0) m_mode = 0;
            else if (rd_ready) begin
                void'(m_rdq.pop_front());
                if (m_rdq.size() == 0) m_mode = 0;
            end
        end
    endtask

    task automatic check_model();
        chk("armed", 64'(armed), 64'(m_mode == 1 || m_mode == 2));
        chk("done", 64'(done), 64'(m_mode == 3));
        chk("count", 64'(count), 64'(m_buf.size()));
        chk("wrapped", 64'(wrapped), 64'(m_total > DEPTH));
        chk("rd_valid", 64'(rd_valid), 64'(m_mode == 3 && m_rdq.size() != 0));
        if (m_mode == 3 && m_rdq.size() != 0) begin
            chk("rd_pc", 64'(rd_pc), 64'(m_rdq[0][EW-1:CTRL_W]));
            chk("rd_ctrl", 64'(rd_ctrl), 64'(m_rdq[0][CTRL_W-1:0]));
            chk("rd_last", 64'(rd_last), 64'(m_rdq.size() == 1));
        end
    endtask

    // Model advances with the inputs currently applied, then the DUT clocks.
    task automatic cycle();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        arm = 1'b0;
        force_trig = 1'b0;
        cap_valid = 1'b0;
        rd_ready = 1'b0;
        rst = 1'b0;
    endtask

    task automatic capture(input logic [PC_W-1:0] pc);
        cap_valid = 1'b1;
        cap_pc = pc;
        cap_ctrl = ctrl_of(pc);
        cycle();
        check_model();
        cap_valid = 1'b0;
    endtask

    bit            bp_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [PC_W-1:0]   got_pc[$];
    logic [CTRL_W-1:0] got_ctrl[$];
    int            n_last;
    int            last_idx;

    task automatic drain(input bit use_bp, input int max_cycles);
        int k = 0;
        got_pc.delete();
        got_ctrl.delete();
        n_last = 0;
        last_idx = -1;
        while (m_mode == 3 && k < max_cycles) begin
            rd_ready = use_bp ? bp_pat[k % 6] : 1'b1;
            if (rd_valid && rd_ready) begin
                got_pc.push_back(rd_pc);
                got_ctrl.push_back(rd_ctrl);
                if (rd_last) begin
                    n_last++;
                    last_idx = got_pc.size() - 1;
                end
            end
            cycle();
            check_model();
            k++;
        end
        rd_ready = 1'b0;
        chk("drain_finished", 64'(done), 64'd0);
    endtask

    task automatic check_window(input string tag, input int n, input logic [PC_W-1:0] first);
        chk({tag, "_delivered"}, 64'(got_pc.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            logic [PC_W-1:0] exp_pc;
            exp_pc = first + PC_W'(4 * i);
            chk({tag, "_pc"}, 64'(i < got_pc.size() ? got_pc[i] : '1), 64'(exp_pc));
            chk({tag, "_ctrl"}, 64'(i < got_ctrl.size() ? got_ctrl[i] : '1), 64'(ctrl_of(exp_pc)));
        end
        chk({tag, "_last_once"}, 64'(n_last), 64'd1);
        chk({tag, "_last_pos"}, 64'(last_idx), 64'(n - 1));
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic              arm;
        logic [AW-1:0]     post_len;
        logic              cap_valid;
        logic [PC_W-1:0]   pc;
        logic [CTRL_W-1:0] ctrl;
        logic              force_trig;
        logic              rd_ready;
        logic              e_armed;
        logic              e_done;
        logic [AW:0]       e_count;
        logic              e_rd_valid;
        logic [PC_W-1:0]   e_pc;
        logic [CTRL_W-1:0] e_ctrl;
        logic              e_last;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        // arm,post,cv,pc,ctrl,force,rdy | armed,done,count,rdv,pc,ctrl,last
        tbl[0]  = '{1'b1, 3'd1, 1'b0, 32'h000, 14'h000, 1'b0, 1'b0,
                    1'b1, 1'b0, 4'd0, 1'b0, 32'h000, 14'h000, 1'b0};
        tbl[1]  = '{1'b0, 3'd0, 1'b1, 32'h100, 14'h011, 1'b0, 1'b0,
                    1'b1, 1'b0, 4'd1, 1'b0, 32'h000, 14'h000, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 1'b1, 32'h104, 14'h022, 1'b1, 1'b0,
                    1'b1, 1'b0, 4'd2, 1'b0, 32'h000, 14'h000, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 1'b0, 32'h000, 14'h000, 1'b0, 1'b0,
                    1'b1, 1'b0, 4'd2, 1'b0, 32'h000, 14'h000, 1'b0};
        tbl[4]  = '{1'b0, 3'd0, 1'b1, 32'h108, 14'h033, 1'b0, 1'b0,
                    1'b0, 1'b1, 4'd3, 1'b1, 32'h100, 14'h011, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 1'b0, 32'h000, 14'h000, 1'b0, 1'b1,
                    1'b0, 1'b1, 4'd3, 1'b1, 32'h104, 14'h022, 1'b0};
        tbl[6]  = '{1'b0, 3'd0, 1'b0, 32'h000, 14'h000, 1'b0, 1'b0,
                    1'b0, 1'b1, 4'd3, 1'b1, 32'h104, 14'h022, 1'b0};
        tbl[7]  = '{1'b0, 3'd0, 1'b0, 32'h000, 14'h000, 1'b0, 1'b1,
                    1'b0, 1'b1, 4'd3, 1'b1, 32'h108, 14'h033, 1'b1};
        tbl[8]  = '{1'b0, 3'd0, 1'b0, 32'h000, 14'h000, 1'b0, 1'b1,
                    1'b0, 1'b0, 4'd3, 1'b0, 32'h000, 14'h000, 1'b0};
        tbl[9]  = '{1'b1, 3'd0, 1'b0, 32'h000, 14'h000, 1'b0, 1'b0,
                    1'b1, 1'b0, 4'd0, 1'b0, 32'h000, 14'h000, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 1'b0, 32'h000, 14'h000, 1'b1, 1'b0,
                    1'b0, 1'b1, 4'd0, 1'b0, 32'h000, 14'h000, 1'b0};
        tbl[11] = '{1'b0, 3'd0, 1'b0, 32'h000, 14'h000, 1'b0, 1'b0,
                    1'b0, 1'b0, 4'd0, 1'b0, 32'h000, 14'h000, 1'b0};
        tbl[12] = '{1'b0, 3'd0, 1'b1, 32'h200, 14'h044, 1'b0, 1'b0,
                    1'b0, 1'b0, 4'd0, 1'b0, 32'h000, 14'h000, 1'b0};

        // ---------------- reset ----------------
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_pc", 64'(rd_pc), 64'd0);
        chk("rst_rd_ctrl", 64'(rd_ctrl), 64'd0);
        chk("rst_rd_last", 64'(rd_last), 64'd0);
        chk("rst_armed", 64'(armed), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_wrapped", 64'(wrapped), 64'd0);

        // ---------------- table ----------------
        trig_en = 1'b0;
        for (int i = 0; i < 13; i++) begin
            arm = tbl[i].arm;
            post_len = tbl[i].post_len;
            cap_valid = tbl[i].cap_valid;
            cap_pc = tbl[i].pc;
            cap_ctrl = tbl[i].ctrl;
            force_trig = tbl[i].force_trig;
            rd_ready = tbl[i].rd_ready;
            cycle();
            chk($sformatf("tbl%0d_armed", i), 64'(armed), 64'(tbl[i].e_armed));
            chk($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].e_done));
            chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_count));
            chk($sformatf("tbl%0d_wrapped", i), 64'(wrapped), 64'd0);
            chk($sformatf("tbl%0d_rd_valid", i), 64'(rd_valid), 64'(tbl[i].e_rd_valid));
            if (tbl[i].e_rd_valid) begin
                chk($sformatf("tbl%0d_rd_pc", i), 64'(rd_pc), 64'(tbl[i].e_pc));
                chk($sformatf("tbl%0d_rd_ctrl", i), 64'(rd_ctrl), 64'(tbl[i].e_ctrl));
                chk($sformatf("tbl%0d_rd_last", i), 64'(rd_last), 64'(tbl[i].e_last));
            end
        end
        clear_inputs();

        // ---------------- PC-match trigger, post_len=2 ----------------
        post_len = 3'd2;
        trig_en = 1'b1;
        trig_pc = 32'h10;
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        check_model();
        for (int i = 0; i < 7; i++) capture(PC_W'(4 * i));
        chk("match_done", 64'(done), 64'd1);
        chk("match_count", 64'(count), 64'd7);
        chk("match_wrapped", 64'(wrapped), 64'd0);
        drain(1'b0, 20);
        check_window("match", 7, 32'h0);

        // ---------------- wrap + backpressure ----------------
        post_len = 3'd3;
        trig_pc = 32'h30;
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        check_model();
        for (int i = 0; i < 16; i++) capture(PC_W'(4 * i));
        chk("wrap_done", 64'(done), 64'd1);
        chk("wrap_count", 64'(count), 64'd8);
        chk("wrap_wrapped", 64'(wrapped), 64'd1);
        drain(1'b1, 40);
        check_window("wrap", 8, 32'h20);
        chk("wrap_count_kept", 64'(count), 64'd8);
        chk("wrap_wrapped_kept", 64'(wrapped), 64'd1);

        // ---------------- post-trigger gaps ----------------
        begin
            logic [PC_W-1:0] next_pc;
            post_len = 3'd3;
            trig_pc = 32'h10;
            arm = 1'b1;
            cycle();
            arm = 1'b0;
            check_model();
            for (int i = 0; i < 5; i++) capture(PC_W'(4 * i));
            next_pc = 32'h14;
            for (int j = 0; j < 6; j++) begin
                cap_valid = bp_pat[j];
                cap_pc = next_pc;
                cap_ctrl = ctrl_of(next_pc);
                if (bp_pat[j]) next_pc = next_pc + 32'd4;
                cycle();
                check_model();
                if (j == 4) chk("gap_not_done_yet", 64'(done), 64'd0);
                if (j == 5) chk("gap_done", 64'(done), 64'd1);
            end
            cap_valid = 1'b0;
            chk("gap_count", 64'(count), 64'd8);
            drain(1'b0, 20);
            check_window("gap", 8, 32'h0);
        end

        // ---------------- re-arm mid-POST, then reset mid-read ----------------
        post_len = 3'd3;
        trig_pc = 32'h10;
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        for (int i = 0; i < 6; i++) capture(PC_W'(4 * i));
        chk("rearm_in_post", 64'(armed), 64'd1);
        arm = 1'b1;
        post_len = 3'd1;
        cap_valid = 1'b1;
        cap_pc = 32'h18;
        cap_ctrl = ctrl_of(32'h18);
        cycle();
        arm = 1'b0;
        cap_valid = 1'b0;
        chk("rearm_armed", 64'(armed), 64'd1);
        chk("rearm_count", 64'(count), 64'd0);
        chk("rearm_wrapped", 64'(wrapped), 64'd0);
        check_model();
        for (int i = 0; i < 6; i++) capture(PC_W'(4 * i));
        chk("rearm_done", 64'(done), 64'd1);
        chk("rearm_count6", 64'(count), 64'd6);
        rd_ready = 1'b1;
        cycle();
        check_model();
        cycle();
        check_model();
        rd_ready = 1'b1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        rd_ready = 1'b0;
        chk("midrd_rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("midrd_rst_rd_pc", 64'(rd_pc), 64'd0);
        chk("midrd_rst_rd_ctrl", 64'(rd_ctrl), 64'd0);
        chk("midrd_rst_rd_last", 64'(rd_last), 64'd0);
        chk("midrd_rst_armed", 64'(armed), 64'd0);
        chk("midrd_rst_done", 64'(done), 64'd0);
        chk("midrd_rst_count", 64'(count), 64'd0);
        chk("midrd_rst_wrapped", 64'(wrapped), 64'd0);
        cycle();
        check_model();

        // ---------------- randomized against the model ----------------
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            arm = (m_mode == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 79) == 0);
            if (arm) begin
                post_len = AW'($urandom_range(0, 7));
                trig_en = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 49) == 0) trig_pc = PC_W'($urandom_range(0, 31) * 4);
            cap_valid = ($urandom_range(0, 9) < 7);
            cap_pc = PC_W'($urandom_range(0, 31) * 4);
            cap_ctrl = CTRL_W'($urandom);
            force_trig = ($urandom_range(0, 29) == 0);
            rd_ready = ($urandom_range(0, 9) < 6);
            cycle();
            check_model();
        end
        clear_inputs();
        cycle();
        check_model();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
